// File: rtl/receive.sv
// UART receiver for the SPART: oversampled 8N1 deserializer holding the last byte
// for the bus mux, with data-available, framing-error and overrun flags.
module receive #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       brg_tick,
   input  logic       rxd,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   output logic [7:0] rx_data,
   output logic       rda,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] sample_cnt_reg, sample_cnt_next;
   logic [3:0]    bit_cnt_reg, bit_cnt_next;
   logic [7:0]    shift_reg, shift_next;
   logic          rxd_meta, rxd_s;
   logic          done;
   logic          rd_strobe;

   assign rd_strobe = iocs & iorw & (ioaddr == 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta       <= 1'b1;
         rxd_s          <= 1'b1;
         state_reg      <= IDLE;
         sample_cnt_reg <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= 8'hFF;
      end else begin
         rxd_meta       <= rxd;
         rxd_s          <= rxd_meta;
         state_reg      <= state_next;
         sample_cnt_reg <= sample_cnt_next;
         bit_cnt_reg    <= bit_cnt_next;
         shift_reg      <= shift_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      sample_cnt_next = sample_cnt_reg;
      bit_cnt_next    = bit_cnt_reg;
      shift_next      = shift_reg;
      done            = 1'b0;
      if (brg_tick) begin
         case (state_reg)
            IDLE: begin
               if (!rxd_s) begin
                  state_next      = START;
                  sample_cnt_next = '0;
               end
            end
            START: begin
               // Mid-start-bit recheck rejects short low glitches
               if (sample_cnt_reg == HALF_LAST) begin
                  if (!rxd_s) begin
                     state_next      = DATA;
                     sample_cnt_next = '0;
                     bit_cnt_next    = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  sample_cnt_next = sample_cnt_reg + CW'(1);
               end
            end
            DATA: begin
               if (sample_cnt_reg == FULL_LAST) begin
                  shift_next      = {rxd_s, shift_reg[7:1]};
                  bit_cnt_next    = bit_cnt_reg + 4'd1;
                  sample_cnt_next = '0;
                  if (bit_cnt_reg == 4'd7) state_next = STOP;
               end else begin
                  sample_cnt_next = sample_cnt_reg + CW'(1);
               end
            end
            STOP: begin
               if (sample_cnt_reg == FULL_LAST) begin
                  done            = 1'b1;
                  sample_cnt_next = '0;
                  state_next      = rxd_s ? IDLE : BREAK;
               end else begin
                  sample_cnt_next = sample_cnt_reg + CW'(1);
               end
            end
            BREAK: begin
               // A held-low line must return high before a new start is accepted
               if (rxd_s) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= 8'h00;
         rda       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // Frame completion takes priority over a coincident read
         if (done) begin
            rx_data   <= shift_reg;
            rda       <= 1'b1;
            frame_err <= ~rxd_s;
         end else if (rd_strobe) begin
            rda <= 1'b0;
         end
         if (rd_strobe)
            overrun <= 1'b0;
         else if (done && rda)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_receive.sv
// Scoreboard bench for the UART receiver: stimulus pushes expected frames, a monitor
// pops and compares whenever a new byte is presented.
module tb_receive;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       brg_tick = 1'b0;
   logic       rxd = 1'b1;
   logic       iocs = 1'b0;
   logic       iorw = 1'b0;
   logic [1:0] ioaddr = 2'd0;
   logic [7:0] rx_data;
   logic       rda, frame_err, overrun;

   typedef struct {
      logic [7:0] data;
      logic       fe;
      logic       ov;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   cyc = 0;

   receive #(.OVERSAMPLE(16)) dut (
      .clk(clk), .rst(rst), .brg_tick(brg_tick), .rxd(rxd),
      .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .rx_data(rx_data), .rda(rda), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // brg_tick is high on posedges whose number is a multiple of 4
   initial forever begin
      @(negedge clk);
      brg_tick = ((cyc + 1) % 4 == 0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: a new byte is presented when rda rises or rx_data changes
   initial begin
      logic [7:0] data_prev = 8'h00;
      logic       rda_prev = 1'b0;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (!rst && ((rda && !rda_prev) || (rx_data !== data_prev))) begin
            if (sb.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_output: rx_data=%0h rda=%0b with nothing expected (cycle %0d)",
                        rx_data, rda, cyc);
            end else begin
               e = sb.pop_front();
               $display("frame rx_data=%0h fe=%0b ov=%0b (expected %0h fe=%0b ov=%0b)",
                        rx_data, frame_err, overrun, e.data, e.fe, e.ov);
               check("rx_data", rx_data, e.data);
               check("rda_on_frame", rda, 1);
               check("frame_err", frame_err, e.fe);
               check("overrun", overrun, e.ov);
            end
         end
         data_prev = rx_data;
         rda_prev  = rda;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // Start bit falls at negedge c; the stop sample lands on posedge c+611
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input bit rd_at_done, input bit chk_lat);
      int c;
      do @(negedge clk); while (cyc % 4 != 1);
      c = cyc;
      fork
         begin
            rxd = 1'b0;
            repeat (64) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               rxd = b[i];
               repeat (64) @(negedge clk);
            end
            rxd = stop_bit;
            repeat (64) @(negedge clk);
         end
         begin
            while (cyc != c + 610) @(negedge clk);
            if (chk_lat) check("rda_before_stop_tick", rda, 0);
            if (rd_at_done) begin
               iocs = 1'b1; iorw = 1'b1; ioaddr = 2'd0;
            end
            @(negedge clk);
            iocs = 1'b0; iorw = 1'b0;
            if (chk_lat) check("rda_at_stop_tick", rda, 1);
         end
      join
   endtask

   task automatic expect_done();
      check("frame_consumed", sb.size(), 0);
      sb.delete();
   endtask

   task automatic do_read();
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'd0;
      @(negedge clk);
      iocs = 1'b0; iorw = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rda", rda, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_values();
      repeat (1000) @(negedge clk);
      check("idle_rda", rda, 0);

      // Normal frame with latency check, then non-data accesses and a real read
      sb.push_back('{8'hA5, 1'b0, 1'b0});
      send_frame(8'hA5, 1'b1, 0, 1);
      expect_done();
      @(negedge clk); iocs = 1'b1; iorw = 1'b0; ioaddr = 2'd0;
      @(negedge clk); iorw = 1'b1; ioaddr = 2'd1;
      @(negedge clk); iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0;
      check("rda_after_nondata_access", rda, 1);
      do_read();
      check("rda_after_read", rda, 0);
      check("rx_data_after_read", rx_data, 8'hA5);

      // Glitch of 4 ticks must be rejected
      @(negedge clk); rxd = 1'b0;
      repeat (16) @(negedge clk);
      rxd = 1'b1;
      repeat (128) @(negedge clk);
      check("glitch_rda", rda, 0);
      check("glitch_rx_data", rx_data, 8'hA5);
      sb.push_back('{8'h3C, 1'b0, 1'b0});
      send_frame(8'h3C, 1'b1, 0, 0);
      expect_done();
      do_read();

      // Framing error followed by a long break
      sb.push_back('{8'h55, 1'b1, 1'b0});
      send_frame(8'h55, 1'b0, 0, 0);
      repeat (40 * 64) @(negedge clk);
      expect_done();
      check("break_rda", rda, 1);
      rxd = 1'b1;
      repeat (64) @(negedge clk);
      do_read();
      check("break_read_rda", rda, 0);
      check("frame_err_kept_after_read", frame_err, 1);
      sb.push_back('{8'h01, 1'b0, 1'b0});
      send_frame(8'h01, 1'b1, 0, 0);
      expect_done();
      do_read();

      // Overrun, then read coincident with frame completion
      sb.push_back('{8'h11, 1'b0, 1'b0});
      send_frame(8'h11, 1'b1, 0, 0);
      expect_done();
      sb.push_back('{8'h22, 1'b0, 1'b1});
      send_frame(8'h22, 1'b1, 0, 0);
      expect_done();
      do_read();
      check("overrun_read_rda", rda, 0);
      check("overrun_read_clear", overrun, 0);
      sb.push_back('{8'h44, 1'b0, 1'b0});
      send_frame(8'h44, 1'b1, 0, 0);
      expect_done();
      sb.push_back('{8'h33, 1'b0, 1'b0});
      send_frame(8'h33, 1'b1, 1, 0);
      expect_done();
      check("coincident_rda", rda, 1);
      check("coincident_overrun", overrun, 0);

      // Reset after the 4th data bit of 0xC3
      @(negedge clk); rxd = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = (8'hC3 >> i) & 8'h01;
         repeat (64) @(negedge clk);
      end
      rst = 1'b1; rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_values();
      repeat (128) @(negedge clk);
      sb.push_back('{8'hF0, 1'b0, 1'b0});
      send_frame(8'hF0, 1'b1, 0, 0);
      expect_done();

      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
